// File: rtl/tlb_array_pkg.sv
// Shared JTLB types: the 80-bit entry layout as a packed struct.
// Field order matches the CP0 write/read bus.
package tlb_array_pkg;

   localparam int TLB_ENTRY_W = 80;

   typedef struct packed {
      logic [7:0]  asid;
      logic        g;
      logic [18:0] vpn2;
      logic [23:0] pfn1;
      logic        d1;
      logic        v1;
      logic [23:0] pfn0;
      logic        d0;
      logic        v0;
   } tlb_entry_t;

endpackage

// File: rtl/tlb_match_lane.sv
// One translation lane: full hit vector, lowest-index priority,
// even/odd page select. Purely combinational.
module tlb_match_lane
   import tlb_array_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4
) (
   input  tlb_entry_t [ENTRIES-1:0] ents,
   input  logic [31:0]              vaddr,
   input  logic [7:0]               asid,
   output logic                     hit,
   output logic                     multi,
   output logic [IDX_W-1:0]         idx,
   output logic [31:0]              paddr,
   output logic                     valid,
   output logic                     dirty
);

   logic [ENTRIES-1:0] hits;
   logic [23:0]        pfn;
   logic               d;
   logic               v;
   logic               unused_pfn;

   always_comb begin
      hits = '0;
      for (int i = 0; i < ENTRIES; i++)
         hits[i] = (ents[i].vpn2 == vaddr[31:13]) &&
                   (ents[i].g || ents[i].asid == asid);
      idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--)
         if (hits[i]) idx = IDX_W'(i);
   end

   always_comb begin
      if (vaddr[12])
         {pfn, d, v} = {ents[idx].pfn1, ents[idx].d1, ents[idx].v1};
      else
         {pfn, d, v} = {ents[idx].pfn0, ents[idx].d0, ents[idx].v0};
      hit   = |hits;
      multi = $countones(hits) > 1;
      paddr = hit ? {pfn[19:0], vaddr[11:0]} : {20'h0, vaddr[11:0]};
      valid = hit & v;
      dirty = hit & d;
   end

   // Only a 20-bit PFN reaches the 32-bit physical address.
   assign unused_pfn = ^pfn[23:20];

endmodule

// File: rtl/tlb_array.sv
// MIPS32 JTLB: entry registers, registered lookup channels,
// TLBR read port, TLBP probe and the CP0 Random counter.
module tlb_array
   import tlb_array_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4,
   parameter int LOOKUPS = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [LOOKUPS-1:0]      lk_en,
   input  logic [32*LOOKUPS-1:0]   lk_vaddr,
   input  logic [7:0]              lk_asid,
   output logic [32*LOOKUPS-1:0]   lk_paddr,
   output logic [LOOKUPS-1:0]      lk_miss,
   output logic [LOOKUPS-1:0]      lk_valid,
   output logic [LOOKUPS-1:0]      lk_dirty,
   output logic [LOOKUPS-1:0]      lk_multi,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_index,
   input  logic [TLB_ENTRY_W-1:0]  wr_entry,
   input  logic [IDX_W-1:0]        rd_index,
   output logic [TLB_ENTRY_W-1:0]  rd_entry,
   input  logic                    pr_req,
   input  logic [18:0]             pr_vpn2,
   output logic                    pr_done,
   output logic                    pr_miss,
   output logic [IDX_W-1:0]        pr_index,
   input  logic [IDX_W-1:0]        wired,
   input  logic                    wired_we,
   output logic [IDX_W-1:0]        random_index
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

   tlb_entry_t [ENTRIES-1:0] ent;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent      <= '0;
         rd_entry <= '0;
      end else begin
         if (wr_en) ent[wr_index] <= wr_entry;
         rd_entry <= ent[rd_index];
      end
   end

   for (genvar c = 0; c < LOOKUPS; c++) begin : g_lk
      logic             hit, multi, valid, dirty;
      logic [IDX_W-1:0] idx;
      logic [31:0]      paddr;
      logic [31:0]      paddr_q;
      logic             miss_q, valid_q, dirty_q, multi_q;
      logic             unused_idx;

      tlb_match_lane #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_lane (
         .ents  (ent),
         .vaddr (lk_vaddr[32*c +: 32]),
         .asid  (lk_asid),
         .hit   (hit),
         .multi (multi),
         .idx   (idx),
         .paddr (paddr),
         .valid (valid),
         .dirty (dirty)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            paddr_q <= '0;
            miss_q  <= 1'b0;
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
            multi_q <= 1'b0;
         end else if (lk_en[c]) begin
            paddr_q <= paddr;
            miss_q  <= ~hit;
            valid_q <= valid;
            dirty_q <= dirty;
            multi_q <= multi;
         end
      end

      assign lk_paddr[32*c +: 32] = paddr_q;
      assign lk_miss[c]           = miss_q;
      assign lk_valid[c]          = valid_q;
      assign lk_dirty[c]          = dirty_q;
      assign lk_multi[c]          = multi_q;
      assign unused_idx           = ^idx;
   end

   logic             p_hit, p_multi, p_valid, p_dirty;
   logic [IDX_W-1:0] p_idx;
   logic [31:0]      p_paddr;
   logic             unused_probe;

   tlb_match_lane #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_probe (
      .ents  (ent),
      .vaddr ({pr_vpn2, 13'h0}),
      .asid  (lk_asid),
      .hit   (p_hit),
      .multi (p_multi),
      .idx   (p_idx),
      .paddr (p_paddr),
      .valid (p_valid),
      .dirty (p_dirty)
   );

   assign unused_probe = ^{p_multi, p_paddr, p_valid, p_dirty};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pr_done  <= 1'b0;
         pr_miss  <= 1'b0;
         pr_index <= '0;
      end else begin
         pr_done  <= pr_req;
         pr_miss  <= pr_req & ~p_hit;
         pr_index <= (pr_req & p_hit) ? p_idx : '0;
      end
   end

   // Wrapping at or below Wired also covers Wired raised past Random.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         random_index <= LAST;
      else if (wired_we || random_index <= wired)
         random_index <= LAST;
      else
         random_index <= random_index - 1'b1;
   end

endmodule
